// File: rtl/data_mem_controller.sv
// MEM-stage data memory controller: byte-lane transactions, big-endian load formatting, stall.
// Optional LL/SC reservation support is enabled by defining DATA_MEM_LLSC_EN.
module data_mem_controller (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        MEM_Byte,
  input  logic        MEM_Half,
  input  logic        MEM_SignExtend,
  input  logic        MEM_LLSC,
  input  logic [31:0] MEM_Address,
  input  logic [31:0] MEM_WriteData,
  input  logic        MEM_Stall,
  output logic [31:0] MEM_ReadData,
  output logic        MEM_Stall_Controller,
  output logic        MEM_Exc_AdEL,
  output logic        MEM_Exc_AdES,
  output logic [29:0] DataMem_Address,
  output logic [31:0] DataMem_WriteData,
  output logic [3:0]  DataMem_WE,
  output logic        DataMem_Read,
  input  logic [31:0] DataMem_ReadData,
  input  logic        DataMem_Ready
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;

  logic        is_byte, is_half, is_word;
  logic [1:0]  a;
  logic        misaligned, acc, req, complete, capture;
  logic        is_ll, is_sc, sc_fail;
  logic [3:0]  lanes;
  logic [31:0] wdata, ld_fmt, ret_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign a       = MEM_Address[1:0];
  assign is_byte = MEM_Byte;
  assign is_half = ~MEM_Byte & MEM_Half;
  assign is_word = ~MEM_Byte & ~MEM_Half;

  assign misaligned = (is_half & a[0]) | (is_word & (a != 2'b00));

`ifdef DATA_MEM_LLSC_EN
  logic        llsc_valid_q, llsc_valid_d;
  logic [29:0] llsc_addr_q, llsc_addr_d;
  logic        addr_hit;

  assign addr_hit = llsc_valid_q & (llsc_addr_q == MEM_Address[31:2]);
  assign is_ll    = MEM_MemRead & MEM_LLSC;
  assign is_sc    = MEM_MemWrite & MEM_LLSC;
  assign sc_fail  = is_sc & ~addr_hit;

  always_comb begin
    llsc_valid_d = llsc_valid_q;
    llsc_addr_d  = llsc_addr_q;
    if (complete) begin
      if (is_ll) begin
        llsc_valid_d = 1'b1;
        llsc_addr_d  = MEM_Address[31:2];
      end else if (is_sc) begin
        llsc_valid_d = 1'b0;
      end else if (MEM_MemWrite && (llsc_addr_q == MEM_Address[31:2])) begin
        llsc_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      llsc_valid_q <= 1'b0;
      llsc_addr_q  <= '0;
    end else begin
      llsc_valid_q <= llsc_valid_d;
      llsc_addr_q  <= llsc_addr_d;
    end
  end
`else
  logic unused_llsc;
  assign unused_llsc = MEM_LLSC;
  assign is_ll       = 1'b0;
  assign is_sc       = 1'b0;
  assign sc_fail     = 1'b0;
`endif

  assign acc = (MEM_MemRead | MEM_MemWrite) & ~misaligned & ~sc_fail;
  // Gating with reset_n lets an asynchronous reset drop the request in the same cycle.
  assign req = reset_n & (((state_q == StIdle) & acc) | (state_q == StWait));
  assign complete = req & DataMem_Ready;
  assign capture  = complete & (MEM_MemRead | is_sc);

  always_comb begin
    lanes = 4'b1111;
    wdata = MEM_WriteData;
    if (is_byte) begin
      lanes = 4'b1000 >> a;
      wdata = {4{MEM_WriteData[7:0]}};
    end else if (is_half) begin
      lanes = a[1] ? 4'b0011 : 4'b1100;
      wdata = {2{MEM_WriteData[15:0]}};
    end
  end

  always_comb begin
    ld_byte = DataMem_ReadData[31:24];
    unique case (a)
      2'd0: ld_byte = DataMem_ReadData[31:24];
      2'd1: ld_byte = DataMem_ReadData[23:16];
      2'd2: ld_byte = DataMem_ReadData[15:8];
      2'd3: ld_byte = DataMem_ReadData[7:0];
      default: ld_byte = DataMem_ReadData[31:24];
    endcase
    ld_half = a[1] ? DataMem_ReadData[15:0] : DataMem_ReadData[31:16];
    if (is_byte) begin
      ld_fmt = {{24{MEM_SignExtend & ld_byte[7]}}, ld_byte};
    end else if (is_half) begin
      ld_fmt = {{16{MEM_SignExtend & ld_half[15]}}, ld_half};
    end else begin
      ld_fmt = DataMem_ReadData;
    end
  end

  assign ret_data = is_sc ? 32'd1 : ld_fmt;
  assign data_d   = capture ? ret_data : data_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (acc) begin
          if (!DataMem_Ready)  state_d = StWait;
          else if (MEM_Stall)  state_d = StDone;
        end
      end
      StWait: begin
        if (DataMem_Ready) state_d = MEM_Stall ? StDone : StIdle;
      end
      StDone: begin
        if (!MEM_Stall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign MEM_ReadData         = sc_fail ? 32'd0 : (capture ? ret_data : data_q);
  assign MEM_Stall_Controller = req & ~DataMem_Ready;
  assign MEM_Exc_AdEL         = MEM_MemRead & misaligned;
  assign MEM_Exc_AdES         = MEM_MemWrite & misaligned;
  assign DataMem_Address      = MEM_Address[31:2];
  assign DataMem_WriteData    = wdata;
  assign DataMem_WE           = (req & MEM_MemWrite) ? lanes : 4'b0000;
  assign DataMem_Read         = req & MEM_MemRead;

endmodule

// File: tb/tb_data_mem_controller.sv
// Randomized bench for data_mem_controller against a byte-addressed reference model.
// Define DATA_MEM_LLSC_EN for both bench and RTL to exercise LL/SC.
module tb_data_mem_controller;

`ifdef DATA_MEM_LLSC_EN
  localparam bit LlscEn = 1'b1;
`else
  localparam bit LlscEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        MEM_MemRead, MEM_MemWrite, MEM_Byte, MEM_Half, MEM_SignExtend, MEM_LLSC;
  logic [31:0] MEM_Address, MEM_WriteData;
  logic        MEM_Stall;
  logic [31:0] MEM_ReadData;
  logic        MEM_Stall_Controller, MEM_Exc_AdEL, MEM_Exc_AdES;
  logic [29:0] DataMem_Address;
  logic [31:0] DataMem_WriteData;
  logic [3:0]  DataMem_WE;
  logic        DataMem_Read;
  logic [31:0] DataMem_ReadData;
  logic        DataMem_Ready;
  logic        ext_stall;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem     [16];  // memory as seen by the DUT's port
  logic [31:0] ref_mem [16];  // reference model contents
  logic [31:0] held;
  bit          ref_ll_valid;
  logic [29:0] ref_ll_addr;

  always #5 clock = ~clock;

  // Hazard unit: own stall ORed with other stall sources.
  assign MEM_Stall = MEM_Stall_Controller | ext_stall;

  data_mem_controller dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .MEM_MemRead         (MEM_MemRead),
    .MEM_MemWrite        (MEM_MemWrite),
    .MEM_Byte            (MEM_Byte),
    .MEM_Half            (MEM_Half),
    .MEM_SignExtend      (MEM_SignExtend),
    .MEM_LLSC            (MEM_LLSC),
    .MEM_Address         (MEM_Address),
    .MEM_WriteData       (MEM_WriteData),
    .MEM_Stall           (MEM_Stall),
    .MEM_ReadData        (MEM_ReadData),
    .MEM_Stall_Controller(MEM_Stall_Controller),
    .MEM_Exc_AdEL        (MEM_Exc_AdEL),
    .MEM_Exc_AdES        (MEM_Exc_AdES),
    .DataMem_Address     (DataMem_Address),
    .DataMem_WriteData   (DataMem_WriteData),
    .DataMem_WE          (DataMem_WE),
    .DataMem_Read        (DataMem_Read),
    .DataMem_ReadData    (DataMem_ReadData),
    .DataMem_Ready       (DataMem_Ready)
  );

  always @(posedge clock) begin
    if (DataMem_Ready) begin
      for (int i = 0; i < 4; i++) begin
        if (DataMem_WE[i]) mem[DataMem_Address[3:0]][8*i +: 8] = DataMem_WriteData[8*i +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic access(input bit rd, input bit wr, input bit byt, input bit hlf, input bit sx,
                        input bit llsc, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input int ext);
    int          n, a, idx;
    bit          mis, is_sc, sc_ok, sc_fail, acc;
    logic [3:0]  we;
    logic [31:0] wd, v, ret;
    n       = byt ? 1 : (hlf ? 2 : 4);
    a       = int'(addr[1:0]);
    idx     = int'(addr[5:2]);
    mis     = (rd || wr) && ((a % n) != 0);
    is_sc   = LlscEn && wr && llsc;
    sc_ok   = ref_ll_valid && (ref_ll_addr == addr[31:2]);
    sc_fail = is_sc && !sc_ok;
    acc     = (rd || wr) && !mis && !sc_fail;
    we      = 4'b0000;
    for (int i = 0; i < 4; i++) if (i >= a && i < a + n) we[3-i] = 1'b1;
    wd = (n == 1) ? {4{wdata[7:0]}} : ((n == 2) ? {2{wdata[15:0]}} : wdata);
    v  = 32'd0;
    if (acc) begin
      v = ref_mem[idx] >> (8 * (4 - a - n));
      if (n == 1) begin
        v = v & 32'hFF;
        if (sx && v[7]) v = v | 32'hFFFF_FF00;
      end else if (n == 2) begin
        v = v & 32'hFFFF;
        if (sx && v[15]) v = v | 32'hFFFF_0000;
      end
    end
    ret = is_sc ? 32'd1 : v;

    @(negedge clock);
    MEM_MemRead = rd; MEM_MemWrite = wr; MEM_Byte = byt; MEM_Half = hlf;
    MEM_SignExtend = sx; MEM_LLSC = llsc; MEM_Address = addr; MEM_WriteData = wdata;
    ext_stall = 1'b0;
    if (!acc) begin
      DataMem_Ready = 1'($urandom % 2);
      DataMem_ReadData = $urandom;
      #1;
      chk("noacc_read", {31'b0, DataMem_Read}, 32'd0);
      chk("noacc_we", {28'b0, DataMem_WE}, 32'd0);
      chk("noacc_stall", {31'b0, MEM_Stall_Controller}, 32'd0);
      chk("adel", {31'b0, MEM_Exc_AdEL}, {31'b0, rd && mis});
      chk("ades", {31'b0, MEM_Exc_AdES}, {31'b0, wr && mis});
      chk("noacc_rdata", MEM_ReadData, sc_fail ? 32'd0 : held);
    end else begin
      for (int k = 0; k <= waits; k++) begin
        if (k > 0) @(negedge clock);
        ext_stall = (k == waits) && (ext > 0);
        DataMem_Ready = (k == waits);
        DataMem_ReadData = (k == waits) ? mem[idx] : $urandom;
        #1;
        chk("req_read", {31'b0, DataMem_Read}, {31'b0, rd});
        chk("req_we", {28'b0, DataMem_WE}, wr ? {28'b0, we} : 32'd0);
        chk("req_stall", {31'b0, MEM_Stall_Controller}, {31'b0, k < waits});
        chk("req_addr", {2'b0, DataMem_Address}, {2'b0, addr[31:2]});
        chk("req_exc", {30'b0, MEM_Exc_AdEL, MEM_Exc_AdES}, 32'd0);
        if (wr) chk("req_wdata", DataMem_WriteData, wd);
        if ((k == waits) && (rd || is_sc)) chk("ready_rdata", MEM_ReadData, ret);
      end
      if (rd || is_sc) held = ret;
      if (wr) begin
        for (int i = a; i < a + n; i++)
          ref_mem[idx][8*(3-i) +: 8] = wdata[8*(n-1-(i-a)) +: 8];
      end
      if (LlscEn) begin
        if (rd && llsc) begin
          ref_ll_valid = 1'b1;
          ref_ll_addr  = addr[31:2];
        end else if (is_sc) begin
          ref_ll_valid = 1'b0;
        end else if (wr && (ref_ll_addr == addr[31:2])) begin
          ref_ll_valid = 1'b0;
        end
      end
      for (int j = 1; j <= ext; j++) begin
        @(negedge clock);
        ext_stall = (j < ext);
        DataMem_Ready = 1'($urandom % 2);
        DataMem_ReadData = $urandom;
        #1;
        chk("done_read", {31'b0, DataMem_Read}, 32'd0);
        chk("done_we", {28'b0, DataMem_WE}, 32'd0);
        chk("done_stall", {31'b0, MEM_Stall_Controller}, 32'd0);
        chk("done_rdata", MEM_ReadData, held);
      end
    end
    ext_stall = 1'b0;
  endtask

  initial begin
    bit rd, wr, byt, hlf;
    reset_n = 1'b0;
    MEM_MemRead = 0; MEM_MemWrite = 0; MEM_Byte = 0; MEM_Half = 0; MEM_SignExtend = 0;
    MEM_LLSC = 0; MEM_Address = 0; MEM_WriteData = 0; ext_stall = 0;
    DataMem_ReadData = 0; DataMem_Ready = 0;
    held = 0; ref_ll_valid = 0; ref_ll_addr = 0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (2) @(negedge clock);
    #1;
    chk("rst_rdata", MEM_ReadData, 32'd0);
    chk("rst_stall", {31'b0, MEM_Stall_Controller}, 32'd0);
    chk("rst_read", {31'b0, DataMem_Read}, 32'd0);
    chk("rst_we", {28'b0, DataMem_WE}, 32'd0);
    chk("rst_exc", {30'b0, MEM_Exc_AdEL, MEM_Exc_AdES}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // LB 0x103 sign-extended, two wait cycles.
    mem[0] = 32'h1122_33F4;
    ref_mem[0] = 32'h1122_33F4;
    access(1, 0, 1, 0, 1, 0, 32'h0000_0103, 32'h0, 2, 0);
    chk("lb_value", MEM_ReadData, 32'hFFFF_FFF4);
    // SH 0xABCD at 0x202, zero-wait.
    access(0, 1, 0, 1, 0, 0, 32'h0000_0202, 32'h0000_ABCD, 0, 0);
    // Misaligned LW.
    access(1, 0, 0, 0, 0, 0, 32'h0000_0301, 32'h0, 0, 0);
    // LW completing under an external stall.
    access(1, 0, 0, 0, 0, 0, 32'h0000_0208, 32'h0, 1, 3);
    access(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

    // Reset while waiting on memory.
    @(negedge clock);
    MEM_MemRead = 1; MEM_Address = 32'h0000_0010; DataMem_Ready = 0;
    @(negedge clock);
    #1;
    chk("pre_rst_read", {31'b0, DataMem_Read}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_read", {31'b0, DataMem_Read}, 32'd0);
    chk("midrst_we", {28'b0, DataMem_WE}, 32'd0);
    chk("midrst_stall", {31'b0, MEM_Stall_Controller}, 32'd0);
    chk("midrst_rdata", MEM_ReadData, 32'd0);
    held = 0;
    ref_ll_valid = 0;
    @(negedge clock);
    MEM_MemRead = 0;
    reset_n = 1'b1;
    access(1, 0, 0, 0, 0, 0, 32'h0000_0014, 32'h0, 0, 0);

    // LL / intervening SW / SC, then LL / SC.
    access(1, 0, 0, 0, 0, 1, 32'h0000_0400, 32'h0, 1, 0);
    access(0, 1, 0, 0, 0, 0, 32'h0000_0400, 32'h1234_5678, 0, 0);
    access(0, 1, 0, 0, 0, 1, 32'h0000_0400, 32'hCAFE_F00D, 0, 0);
    access(1, 0, 0, 0, 0, 1, 32'h0000_0400, 32'h0, 0, 0);
    access(0, 1, 0, 0, 0, 1, 32'h0000_0400, 32'hCAFE_F00D, 1, 1);
    access(1, 0, 0, 0, 0, 0, 32'h0000_0400, 32'h0, 0, 0);

    for (int t = 0; t < 150; t++) begin
      int kind;
      kind = int'($urandom % 3);
      rd   = (kind == 0);
      wr   = (kind == 1);
      byt  = ($urandom % 3) == 0;
      hlf  = ($urandom % 2) == 0;
      access(rd, wr, byt, hlf, 1'($urandom % 2), ($urandom % 4) == 0,
             {$urandom} & 32'hFFFF_F07F, $urandom, int'($urandom % 4),
             (($urandom % 4) == 0) ? int'($urandom % 3) + 1 : 0);
    end
    // Every word must match between DUT-written memory and the model.
    for (int i = 0; i < 16; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
